// File: rtl/axi_master_bridge_pkg.sv
// Shared AXI widths, fixed transaction attributes and FSM state encodings
// for the axi_master_bridge slice.
package axi_master_bridge_pkg;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned CACHE_W = 4;
  localparam int unsigned PROT_W  = 3;
  localparam int unsigned QOS_W   = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned STRB_W  = 8;
  localparam int unsigned RESP_W  = 2;

  localparam logic [SIZE_W-1:0]  SIZE_8B    = 3'b011;
  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [CACHE_W-1:0] CACHE_DEF  = 4'b0010;
  localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} wr_state_t;
  typedef enum logic {OWN_MEM, OWN_IF} owner_t;

endpackage

// File: rtl/axi_master_wr_ch.sv
// Write channel of axi_master_bridge: single-beat AW/W/B sequencing with
// independent aw/w done flags so the two channels may complete in any order.
module axi_master_wr_ch
  import axi_master_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  input  logic              aw_ready,
  input  logic              w_ready,
  input  logic              b_valid,
  output logic              aw_valid,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic [STRB_W-1:0] w_strb,
  output logic              w_last,
  output logic              b_ready,
  output logic              rsp_valid
);

  wr_state_t state, state_next;
  logic      aw_done, w_done;
  logic      aw_hs, w_hs;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      state <= state_next;
      if (state == W_IDLE && mem_req_valid && mem_we) begin
        aw_addr <= mem_addr;
        w_data  <= mem_wdata;
        w_strb  <= mem_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == W_REQ) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      W_IDLE: if (mem_req_valid && mem_we) state_next = W_REQ;
      W_REQ: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        // Leave as soon as each channel is either already done or finishing now.
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = W_RESP;
      end
      W_RESP: begin
        b_ready = 1'b1;
        if (b_valid) state_next = W_DONE;
      end
      W_DONE: begin
        rsp_valid  = 1'b1;
        state_next = W_IDLE;
      end
      default: state_next = W_IDLE;
    endcase
  end

  assign w_last = w_valid;

endmodule

// File: rtl/axi_master_bridge.sv
// AXI4 single-beat master for instruction fetch and data memory requests.
// Optional sticky error flag `axi_err` is built when AXI_MASTER_ERR_EN is defined.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] INST_ID = 4'b0001,
  parameter logic [ID_W-1:0] DATA_ID = 4'b0000
) (
  input  logic               clk,
  input  logic               rst,
`ifdef AXI_MASTER_ERR_EN
  output logic               axi_err,
`endif
  input  logic               if_req_valid,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_rsp_valid,
  output logic [31:0]        if_inst,
  input  logic               mem_req_valid,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [STRB_W-1:0]  mem_wstrb,
  output logic               mem_rsp_valid,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic [ID_W-1:0]    m_axi_aw_id,
  output logic [ADDR_W-1:0]  m_axi_aw_addr,
  output logic [LEN_W-1:0]   m_axi_aw_len,
  output logic [SIZE_W-1:0]  m_axi_aw_size,
  output logic [BURST_W-1:0] m_axi_aw_burst,
  output logic [CACHE_W-1:0] m_axi_aw_cache,
  output logic [PROT_W-1:0]  m_axi_aw_prot,
  output logic [QOS_W-1:0]   m_axi_aw_qos,
  output logic               m_axi_aw_valid,
  input  logic               m_axi_aw_ready,
  output logic [DATA_W-1:0]  m_axi_w_data,
  output logic [STRB_W-1:0]  m_axi_w_strb,
  output logic               m_axi_w_last,
  output logic               m_axi_w_valid,
  input  logic               m_axi_w_ready,
  input  logic [ID_W-1:0]    m_axi_b_id,
  input  logic [RESP_W-1:0]  m_axi_b_resp,
  input  logic               m_axi_b_valid,
  output logic               m_axi_b_ready,
  output logic [ID_W-1:0]    m_axi_ar_id,
  output logic [ADDR_W-1:0]  m_axi_ar_addr,
  output logic [LEN_W-1:0]   m_axi_ar_len,
  output logic [SIZE_W-1:0]  m_axi_ar_size,
  output logic [BURST_W-1:0] m_axi_ar_burst,
  output logic [CACHE_W-1:0] m_axi_ar_cache,
  output logic [PROT_W-1:0]  m_axi_ar_prot,
  output logic [QOS_W-1:0]   m_axi_ar_qos,
  output logic               m_axi_ar_valid,
  input  logic               m_axi_ar_ready,
  input  logic [ID_W-1:0]    m_axi_r_id,
  input  logic [DATA_W-1:0]  m_axi_r_data,
  input  logic [RESP_W-1:0]  m_axi_r_resp,
  input  logic               m_axi_r_last,
  input  logic               m_axi_r_valid,
  output logic               m_axi_r_ready
);

  rd_state_t         rd_state, rd_next;
  owner_t            rd_owner;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic              mem_rd_req;
  logic              rd_rsp;
  logic              r_hs;
  logic              unused_ok;

  assign mem_rd_req = mem_req_valid && !mem_we;
  assign r_hs       = m_axi_r_valid && m_axi_r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= R_IDLE;
      rd_owner  <= OWN_MEM;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == R_IDLE) begin
        // Data reads win over fetch when both are presented together.
        if (mem_rd_req) begin
          ar_addr_q <= mem_addr;
          ar_id_q   <= DATA_ID;
          rd_owner  <= OWN_MEM;
        end else if (if_req_valid) begin
          ar_addr_q <= if_addr;
          ar_id_q   <= INST_ID;
          rd_owner  <= OWN_IF;
        end
      end
      if (rd_state == R_DATA && m_axi_r_valid) begin
        if (rd_owner == OWN_MEM) mem_rdata <= m_axi_r_data;
        else                     if_inst   <= m_axi_r_data[31:0];
      end
    end
  end

  always_comb begin
    rd_next        = rd_state;
    m_axi_ar_valid = 1'b0;
    m_axi_r_ready  = 1'b0;
    rd_rsp         = 1'b0;
    unique case (rd_state)
      R_IDLE: if (mem_rd_req || if_req_valid) rd_next = R_ADDR;
      R_ADDR: begin
        m_axi_ar_valid = 1'b1;
        if (m_axi_ar_ready) rd_next = R_DATA;
      end
      R_DATA: begin
        m_axi_r_ready = 1'b1;
        if (m_axi_r_valid) rd_next = R_DONE;
      end
      R_DONE: begin
        rd_rsp  = 1'b1;
        rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign if_rsp_valid = rd_rsp && (rd_owner == OWN_IF);

  logic wr_rsp;

  axi_master_wr_ch u_wr_ch (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .aw_ready      (m_axi_aw_ready),
    .w_ready       (m_axi_w_ready),
    .b_valid       (m_axi_b_valid),
    .aw_valid      (m_axi_aw_valid),
    .aw_addr       (m_axi_aw_addr),
    .w_valid       (m_axi_w_valid),
    .w_data        (m_axi_w_data),
    .w_strb        (m_axi_w_strb),
    .w_last        (m_axi_w_last),
    .b_ready       (m_axi_b_ready),
    .rsp_valid     (wr_rsp)
  );

  // Reads and writes never share the mem port, so the OR cannot merge two pulses.
  assign mem_rsp_valid = (rd_rsp && (rd_owner == OWN_MEM)) || wr_rsp;

  assign m_axi_ar_id    = ar_id_q;
  assign m_axi_ar_addr  = ar_addr_q;
  assign m_axi_ar_len   = '0;
  assign m_axi_ar_size  = SIZE_8B;
  assign m_axi_ar_burst = BURST_INCR;
  assign m_axi_ar_cache = CACHE_DEF;
  assign m_axi_ar_prot  = '0;
  assign m_axi_ar_qos   = '0;

  assign m_axi_aw_id    = DATA_ID;
  assign m_axi_aw_len   = '0;
  assign m_axi_aw_size  = SIZE_8B;
  assign m_axi_aw_burst = BURST_INCR;
  assign m_axi_aw_cache = CACHE_DEF;
  assign m_axi_aw_prot  = '0;
  assign m_axi_aw_qos   = '0;

`ifdef AXI_MASTER_ERR_EN
  logic b_hs;
  assign b_hs = m_axi_b_valid && m_axi_b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axi_err <= 1'b0;
    end else begin
      if (r_hs && (m_axi_r_resp != RESP_OKAY || m_axi_r_id != ar_id_q)) axi_err <= 1'b1;
      if (b_hs && (m_axi_b_resp != RESP_OKAY || m_axi_b_id != DATA_ID)) axi_err <= 1'b1;
    end
  end

  assign unused_ok = m_axi_r_last;
`else
  assign unused_ok = ^{m_axi_r_last, m_axi_r_id, m_axi_r_resp, m_axi_b_id, m_axi_b_resp, r_hs};
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: fetch, write, arbitration, overlap,
// backpressure and mid-transaction reset with hand-computed expectations.
module tb_axi_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_inst;
  logic        mem_req_valid, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cnt;

  axi_master_bridge #(.INST_ID(4'b0001), .DATA_ID(4'b0000)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_inst(if_inst),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .m_axi_aw_id(aw_id), .m_axi_aw_addr(aw_addr), .m_axi_aw_len(aw_len),
    .m_axi_aw_size(aw_size), .m_axi_aw_burst(aw_burst), .m_axi_aw_cache(aw_cache),
    .m_axi_aw_prot(aw_prot), .m_axi_aw_qos(aw_qos),
    .m_axi_aw_valid(aw_valid), .m_axi_aw_ready(aw_ready),
    .m_axi_w_data(w_data), .m_axi_w_strb(w_strb), .m_axi_w_last(w_last),
    .m_axi_w_valid(w_valid), .m_axi_w_ready(w_ready),
    .m_axi_b_id(b_id), .m_axi_b_resp(b_resp), .m_axi_b_valid(b_valid),
    .m_axi_b_ready(b_ready),
    .m_axi_ar_id(ar_id), .m_axi_ar_addr(ar_addr), .m_axi_ar_len(ar_len),
    .m_axi_ar_size(ar_size), .m_axi_ar_burst(ar_burst), .m_axi_ar_cache(ar_cache),
    .m_axi_ar_prot(ar_prot), .m_axi_ar_qos(ar_qos),
    .m_axi_ar_valid(ar_valid), .m_axi_ar_ready(ar_ready),
    .m_axi_r_id(r_id), .m_axi_r_data(r_data), .m_axi_r_resp(r_resp),
    .m_axi_r_last(r_last), .m_axi_r_valid(r_valid), .m_axi_r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    mem_req_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_id = 4'h0; b_resp = 2'b00;
    r_valid = 1'b0; r_id = 4'h0; r_resp = 2'b00; r_last = 1'b1; r_data = '0;

    // Reset state
    step(); step();
    check("rst_if_rsp", if_rsp_valid, 0);
    check("rst_mem_rsp", mem_rsp_valid, 0);
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_aw_valid", aw_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_ar_addr", ar_addr, 0);
    rst = 1'b1;
    step();

    // Fetch with zero wait states
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'hDEAD_BEEF_0000_0013;
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    cnt = 0;
    while (cnt < 10 && !if_rsp_valid) begin
      step(); cnt++;
      if (ar_valid) begin
        check("fetch_ar_id", ar_id, 64'h1);
        check("fetch_ar_addr", ar_addr, 64'h8000_0000);
        check("fetch_ar_len", ar_len, 0);
        check("fetch_ar_size", ar_size, 64'h3);
        check("fetch_ar_burst", ar_burst, 64'h1);
        check("fetch_ar_cache", ar_cache, 64'h2);
      end
    end
    check("fetch_latency", cnt, 3);
    check("fetch_if_inst", if_inst, 64'h0000_0013);
    check("fetch_mem_rsp", mem_rsp_valid, 0);
    if_req_valid = 1'b0; r_valid = 1'b0;
    step();
    check("fetch_pulse_1cyc", if_rsp_valid, 0);

    // Data write, aw_ready two cycles behind w_ready
    aw_ready = 1'b0; w_ready = 1'b1;
    mem_req_valid = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_1000;
    mem_wdata = 64'h1122_3344_5566_7788; mem_wstrb = 8'hFF;
    step();
    check("wr_aw_valid0", aw_valid, 1);
    check("wr_w_valid0", w_valid, 1);
    check("wr_w_last", w_last, 1);
    check("wr_aw_addr", aw_addr, 64'h8000_1000);
    check("wr_aw_id", aw_id, 0);
    check("wr_w_data", w_data, 64'h1122_3344_5566_7788);
    check("wr_w_strb", w_strb, 64'hFF);
    step();
    check("wr_w_dropped", w_valid, 0);
    check("wr_aw_held1", aw_valid, 1);
    step();
    check("wr_aw_held2", aw_valid, 1);
    check("wr_aw_addr_stable", aw_addr, 64'h8000_1000);
    aw_ready = 1'b1;
    step();
    check("wr_aw_done", aw_valid, 0);
    check("wr_b_ready", b_ready, 1);
    check("wr_no_early_rsp", mem_rsp_valid, 0);
    b_valid = 1'b1;
    step();
    check("wr_rsp", mem_rsp_valid, 1);
    check("wr_b_ready_off", b_ready, 0);
    mem_req_valid = 1'b0; b_valid = 1'b0;
    step();
    check("wr_rsp_1cyc", mem_rsp_valid, 0);

    // Arbitration: data read beats fetch
    ar_ready = 1'b1; r_valid = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0004;
    mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_2000;
    step();
    check("arb_ar_valid", ar_valid, 1);
    check("arb_first_id", ar_id, 0);
    check("arb_first_addr", ar_addr, 64'h8000_2000);
    step();
    r_valid = 1'b1; r_data = 64'hCAFE_F00D_1234_5678;
    step();
    check("arb_mem_rsp", mem_rsp_valid, 1);
    check("arb_if_rsp_quiet", if_rsp_valid, 0);
    check("arb_mem_rdata", mem_rdata, 64'hCAFE_F00D_1234_5678);
    mem_req_valid = 1'b0; r_valid = 1'b0;
    step();
    check("arb_idle", ar_valid, 0);
    step();
    check("arb_second_valid", ar_valid, 1);
    check("arb_second_id", ar_id, 1);
    check("arb_second_addr", ar_addr, 64'h8000_0004);
    step();
    r_valid = 1'b1; r_data = 64'h0000_0000_0000_0067;
    step();
    check("arb_if_rsp", if_rsp_valid, 1);
    check("arb_if_inst", if_inst, 64'h67);
    check("arb_mem_rdata_kept", mem_rdata, 64'hCAFE_F00D_1234_5678);
    if_req_valid = 1'b0; r_valid = 1'b0;
    step();

    // Backpressure on R
    if_req_valid = 1'b1; if_addr = 64'h8000_0010;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      check("bp_r_ready", r_ready, 1);
      check("bp_ar_valid", ar_valid, 0);
      check("bp_no_rsp", if_rsp_valid, 0);
      step();
    end
    r_valid = 1'b1; r_data = 64'h0000_0000_0000_0033;
    step();
    check("bp_rsp", if_rsp_valid, 1);
    check("bp_inst", if_inst, 64'h33);
    if_req_valid = 1'b0; r_valid = 1'b0;
    step();

    // Overlap: fetch in R_DATA while a data write runs
    if_req_valid = 1'b1; if_addr = 64'h8000_0008;
    step(); step();
    aw_ready = 1'b1; w_ready = 1'b1;
    mem_req_valid = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_3000;
    mem_wdata = 64'hA5A5_5A5A_0F0F_F0F0; mem_wstrb = 8'h0F;
    step();
    check("ov_r_ready", r_ready, 1);
    check("ov_aw_valid", aw_valid, 1);
    check("ov_w_valid", w_valid, 1);
    check("ov_w_data", w_data, 64'hA5A5_5A5A_0F0F_F0F0);
    check("ov_w_strb", w_strb, 64'h0F);
    step();
    check("ov_b_ready", b_ready, 1);
    b_valid = 1'b1; r_valid = 1'b1; r_data = 64'h1234_5678_0000_0093;
    step();
    check("ov_if_rsp", if_rsp_valid, 1);
    check("ov_mem_rsp", mem_rsp_valid, 1);
    check("ov_if_inst", if_inst, 64'h93);
    check("ov_mem_rdata_kept", mem_rdata, 64'hCAFE_F00D_1234_5678);
    if_req_valid = 1'b0; mem_req_valid = 1'b0; b_valid = 1'b0; r_valid = 1'b0;
    step();
    check("ov_if_rsp_off", if_rsp_valid, 0);
    check("ov_mem_rsp_off", mem_rsp_valid, 0);

    // Reset in W_RESP
    mem_req_valid = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_4000;
    mem_wdata = 64'h0102_0304_0506_0708; mem_wstrb = 8'hF0;
    step(); step();
    check("rr_b_ready_pre", b_ready, 1);
    rst = 1'b0; mem_req_valid = 1'b0;
    #1;
    check("rr_b_ready_async", b_ready, 0);
    check("rr_aw_valid", aw_valid, 0);
    check("rr_w_valid", w_valid, 0);
    check("rr_mem_rsp", mem_rsp_valid, 0);
    check("rr_if_inst_cleared", if_inst, 0);
    check("rr_mem_rdata_cleared", mem_rdata, 0);
    step();
    rst = 1'b1;
    step();
    check("rr_idle_aw", aw_valid, 0);
    check("rr_idle_b", b_ready, 0);
    check("rr_no_rsp", mem_rsp_valid, 0);
    b_valid = 1'b1;
    mem_req_valid = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_5000;
    cnt = 0;
    while (cnt < 10 && !mem_rsp_valid) begin
      step(); cnt++;
    end
    check("rr_new_wr_latency", cnt, 3);
    check("rr_new_aw_addr", aw_addr, 64'h8000_5000);
    mem_req_valid = 1'b0; b_valid = 1'b0;
    step();
    check("rr_new_rsp_off", mem_rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- AXI4 master that turns the core's instruction-fetch and data-memory requests into single-beat AXI4 transactions.
- Sits between the core/cache request ports and the AXI slave memory model.
- Independent read and write FSMs. At most one read and one write outstanding at any time.
- Every transaction uses the fixed attributes the slave accepts: len=0, size=3'b011, burst=INCR, cache=4'b0010, prot=0, qos=0.

Parameters:
- INST_ID, 4'b0001, ARID used for instruction fetch
- DATA_ID, 4'b0000, ARID/AWID used for data reads and writes

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (rst==0 resets)
- if_req_valid  in  1  fetch request; held until if_rsp_valid
- if_addr  in  64  fetch address
- if_rsp_valid  out  1  one-cycle pulse: fetch complete
- if_inst  out  32  fetched instruction, taken from r_data[31:0]
- mem_req_valid  in  1  data request; held until mem_rsp_valid
- mem_we  in  1  1=write, 0=read
- mem_addr  in  64  data address
- mem_wdata  in  64  write data
- mem_wstrb  in  8  write strobes
- mem_rsp_valid  out  1  one-cycle pulse: data read or write complete
- mem_rdata  out  64  read data
- m_axi_aw_{id,addr,len,size,burst,cache,prot,qos}  out  4/64/8/3/2/4/3/4  AW payload
- m_axi_aw_valid out 1, m_axi_aw_ready in 1
- m_axi_w_data out 64, m_axi_w_strb out 8, m_axi_w_last out 1, m_axi_w_valid out 1, m_axi_w_ready in 1
- m_axi_b_id in 4, m_axi_b_resp in 2, m_axi_b_valid in 1, m_axi_b_ready out 1
- m_axi_ar_{id,addr,len,size,burst,cache,prot,qos}  out  4/64/8/3/2/4/3/4  AR payload
- m_axi_ar_valid out 1, m_axi_ar_ready in 1
- m_axi_r_id in 4, m_axi_r_data in 64, m_axi_r_resp in 2, m_axi_r_last in 1, m_axi_r_valid in 1, m_axi_r_ready out 1

Behaviour:
- Reset: both FSMs go to IDLE. All valid/ready/rsp outputs are 0. Latched addr/data/strb/id registers and if_inst/mem_rdata are 0.
- Payload outputs always come from the latched registers, so they stay stable while valid is high.
- Read FSM states: R_IDLE, R_ADDR, R_DATA, R_DONE.
  - R_IDLE: if mem_req_valid && !mem_we, latch mem_addr, DATA_ID and owner=MEM. Otherwise, if if_req_valid, latch if_addr, INST_ID and owner=IF. Go to R_ADDR. Data read beats fetch when both request together.
  - R_ADDR: ar_valid=1. On ar_valid && ar_ready, go to R_DATA.
  - R_DATA: r_ready=1. On r_valid && r_ready, capture r_data into mem_rdata (owner MEM) or r_data[31:0] into if_inst (owner IF), then go to R_DONE.
  - R_DONE: one cycle. Pulse the owner's rsp_valid, then go to R_IDLE.
  - Response routing uses the latched owner, not r_id. r_last is ignored because len=0.
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_DONE.
  - W_IDLE: on mem_req_valid && mem_we, latch addr/wdata/wstrb, clear aw_done and w_done, go to W_REQ.
  - W_REQ: aw_valid = !aw_done and w_valid = !w_done; both assert in the same first cycle. w_last=1 whenever w_valid=1.
  - Each handshake sets its own done flag. When both are done, or both complete in the same cycle, go to W_RESP.
  - W_RESP: b_ready=1. On b handshake, go to W_DONE.
  - W_DONE: pulse mem_rsp_valid, then go to W_IDLE.
- Requester contract: the requester samples rsp_valid and drops or replaces its valid by the next edge. Neither FSM re-samples requests in its DONE cycle.
- Concurrency:
  - A fetch read may overlap a data write.
  - A data read and a data write never coexist, because the mem port carries one request at a time.
  - If the read and write FSMs finish in the same cycle, each drives only its own rsp signal.
- Reset mid-transaction: FSMs drop to IDLE immediately and valids deassert asynchronously. The request is abandoned; no rsp pulse is generated.
- Minimum latency with ready/valid tied high: 3 cycles from request to rsp pulse (ADDR, DATA, DONE).

Optional Feature:
- Macro: AXI_MASTER_ERR_EN.
- Defined:
  - Adds output port axi_err (1 bit), sticky, cleared only by reset.
  - Set on an r handshake with r_resp != 2'b00 or r_id != latched ID.
  - Set on a b handshake with b_resp != 2'b00 or b_id != DATA_ID.
  - Data is still delivered and the FSMs proceed normally.
- Undefined: the port is absent; resp and id inputs are ignored.

Decomposition:
- Shared package/defines:
  - AXI bus widths (ID 4, ADDR 64, LEN 8, SIZE 3, BURST 2, CACHE 4, PROT 3, QOS 4, DATA 64, STRB 8, RESP 2)
  - Constants SIZE_8B=3'b011, BURST_INCR=2'b01, CACHE_DEF=4'b0010, RESP_OKAY=2'b00
  - Read and write state encodings
- Sub-module: axi_master_wr_ch, containing the write FSM and the aw/w done flags. The read path stays inline.

Test Plan:
- Fetch: if_addr=0x8000_0000, slave returns r_data=0xDEAD_BEEF_0000_0013 -> AR with id=1, len=0, size=3'b011, burst=01. if_inst=0x0000_0013; if_rsp_valid pulses for exactly 1 cycle, 3 cycles after the request with zero wait states.
- Data write: addr=0x8000_1000, wdata=0x1122_3344_5566_7788, wstrb=0xFF, with aw_ready delayed 2 cycles behind w_ready -> w_valid drops after its handshake and aw_valid holds until accepted. Then one b handshake, then one mem_rsp_valid pulse.
- Arbitration: if_req_valid and a mem read asserted in the same cycle -> the first AR has id=0 (mem); the fetch AR (id=1) issues after mem_rsp_valid.
- Overlap: a fetch read in progress while a mem write is issued -> AR/R and AW/W/B interleave. Both rsp pulses occur and their data is correct.
- Backpressure: r_valid held low for 10 cycles -> r_ready stays 1 and ar_valid stays 0. No rsp pulse occurs before the r handshake.
- Reset: rst=0 asserted during W_RESP -> aw/w/b signals and mem_rsp_valid go to 0 immediately. After release the block is idle and accepts a new request. With AXI_MASTER_ERR_EN, r_resp=2'b10 sets axi_err=1 and only reset clears it.
